// File: rtl/axis_pkg.sv
// Shared types for the AXI-stream packet FIFO: write-side FSM states,
// a beat record at the default width, and the pointer-width helper.
package axis_pkg;

    localparam int AXIS_DATA_W = 16;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

    typedef enum logic {
        W_STORE,
        W_DROP
    } wr_state_t;

    // One stored beat at the default width. The stored layout inside the
    // FIFO has the same {data, keep, last} order at any DATA_W.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic [AXIS_KEEP_W-1:0] keep;
        logic                   last;
    } axis_beat_t;

    // The pointer carries one extra bit so that full and empty differ.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// Simple dual-port beat storage: one write port and one registered read
// port. The read register doubles as the FIFO output stage, so it holds
// its value when no read is requested and clears on reset.
module axis_pkt_fifo_mem
    import axis_pkg::*;
#(
    parameter int WIDTH = 19,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read with enable; reset clears the visible output.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-stream packet FIFO. Beats are held until their
// packet's last beat is stored, then released on the master side.
// Packets longer than DEPTH beats are discarded whole with a drop pulse.
// Optional build macro AXIS_PKT_FIFO_STATS_EN adds saturating packet and
// drop counters as extra output ports.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    localparam int KEEP_W = DATA_W / 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [KEEP_W-1:0] r_keep,
    input  logic              r_last,
    output logic              t_valid,
    input  logic              t_ready,
    output logic [DATA_W-1:0] t_data,
    output logic [KEEP_W-1:0] t_keep,
    output logic              t_last,
    output logic [PW-1:0]     pkt_avail,
`ifdef AXIS_PKT_FIFO_STATS_EN
    output logic [31:0]       pkt_count,
    output logic [15:0]       drop_count,
`endif
    output logic              drop
);

    localparam int BW = DATA_W + KEEP_W + 1;

    wr_state_t       state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   wr_commit_q, wr_commit_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   avail_q, avail_d;
    logic            t_valid_q, t_valid_d;
    logic            drop_q, drop_d;

    logic [PW-1:0]   used;
    logic [PW-1:0]   pend;
    logic            full, oversize, wr_en, commit, load, t_acc;
    logic [BW-1:0]   rd_data;

    assign used     = wr_ptr_q - rd_ptr_q;
    assign pend     = wr_ptr_q - wr_commit_q;
    assign full     = (used == PW'(DEPTH));
    // Only reachable once the current packet alone occupies every slot.
    assign oversize = r_valid && (pend == PW'(DEPTH));

    // Write FSM: store beats and commit on last, or swallow an oversize packet.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        r_ready     = 1'b0;
        wr_en       = 1'b0;
        commit      = 1'b0;
        drop_d      = 1'b0;
        case (state_q)
            W_STORE: begin
                r_ready = !full;
                if (oversize) begin
                    state_d  = W_DROP;
                    wr_ptr_d = wr_commit_q;
                end else if (r_valid && !full) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (r_last) begin
                        commit      = 1'b1;
                        wr_commit_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            W_DROP: begin
                r_ready = 1'b1;
                if (r_valid && r_last) begin
                    drop_d  = 1'b1;
                    state_d = W_STORE;
                end
            end
            default: state_d = W_STORE;
        endcase
        if (rst) begin
            r_ready = 1'b0;
        end
    end

    // Read side: refill the output stage from committed beats only.
    always_comb begin
        t_acc     = t_valid_q && t_ready;
        load      = (!t_valid_q || t_ready) && (rd_ptr_q != wr_commit_q);
        rd_ptr_d  = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
        t_valid_d = load || (t_valid_q && !t_ready);
        avail_d   = avail_q;
        if (commit && !(t_acc && t_last)) begin
            avail_d = avail_q + 1'b1;
        end else if (!commit && t_acc && t_last) begin
            avail_d = avail_q - 1'b1;
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= W_STORE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            avail_q     <= '0;
            t_valid_q   <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            avail_q     <= avail_d;
            t_valid_q   <= t_valid_d;
            drop_q      <= drop_d;
        end
    end

    axis_pkt_fifo_mem #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i ({r_data, r_keep, r_last}),
        .rd_en_i   (load),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data)
    );

    assign {t_data, t_keep, t_last} = rd_data;
    assign t_valid   = t_valid_q;
    assign pkt_avail = avail_q;
    assign drop      = drop_q;

`ifdef AXIS_PKT_FIFO_STATS_EN
    logic [31:0] pkt_count_q;
    logic [15:0] drop_count_q;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (t_acc && t_last && (pkt_count_q != '1)) begin
                pkt_count_q <= pkt_count_q + 1'b1;
            end
            if (drop_q && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + 1'b1;
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule
